// File: rtl/alu_pkg.sv
// Shared ALUFun codes, result-class codes and flag type for the pipelined ALU.
package alu_pkg;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_MUL   = 6'b000010;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_NOR   = 6'b010001;
    localparam logic [5:0] ALU_PASSA = 6'b011010;
    localparam logic [5:0] ALU_SLL   = 6'b100000;
    localparam logic [5:0] ALU_SRL   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_EQ    = 6'b110011;
    localparam logic [5:0] ALU_NE    = 6'b110001;
    localparam logic [5:0] ALU_LT    = 6'b110101;
    localparam logic [5:0] ALU_LEZ   = 6'b111101;
    localparam logic [5:0] ALU_LTZ   = 6'b111011;
    localparam logic [5:0] ALU_GTZ   = 6'b111111;

    // Result class is ALUFun[5:4]
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;
    localparam logic [1:0] CLS_CMP   = 2'b11;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } alu_flags_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational log2(WIDTH)-stage barrel shifter for SLL / SRL / SRA.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [clog2(WIDTH)-1:0] amt,
    input  logic [WIDTH-1:0]        data,
    input  logic                    left,
    input  logic                    arith,
    output logic [WIDTH-1:0]        result
);

    localparam int unsigned SHW = clog2(WIDTH);

    always_comb begin
        result = data;
        for (int unsigned i = 0; i < SHW; i++) begin
            if (amt[i]) begin
                if (left)
                    result = result << (1 << i);
                else if (arith)
                    result = WIDTH'($signed(result) >>> (1 << i));
                else
                    result = result >> (1 << i);
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU (S1: compute, S2: select/output).
// Optional shift-add multiplier in S1 enabled by defining ALU_PIPE_MULT_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Sign,
    input  logic [5:0]       ALUFun,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outZ,
    output logic [TAG_W-1:0] out_tag,
    output logic             flagZ,
    output logic             flagV,
    output logic             flagN,
    output logic             illegal
);

    localparam int unsigned SHW = clog2(WIDTH);

    logic [WIDTH:0]   ext_a, ext_b, sum;
    logic [WIDTH-1:0] logic_res, shift_res;
    alu_flags_t       add_flags;
    logic             is_add, a_sign, a_zero, cmp_bit, legal;
    logic             s2_adv, s1_adv, accept;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_sum_q, s1_sum_d, s1_logic_q, s1_logic_d, s1_shift_q, s1_shift_d;
    alu_flags_t       s1_flags_q, s1_flags_d;
    logic             s1_cmp_q, s1_cmp_d, s1_ill_q, s1_ill_d;
    logic [1:0]       s1_cls_q, s1_cls_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             out_valid_q, out_valid_d, out_ill_q, out_ill_d;
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    alu_flags_t       out_flags_q, out_flags_d;

`ifdef ALU_PIPE_MULT_EN
    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    logic [1:0]         mul_state_q, mul_state_d;
    logic [SHW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_hi_s;
    logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d, mul_step;
    logic [WIDTH:0]     mul_hi_sum;
    logic               mul_sign_q, mul_sign_d, mul_v, is_mul;
`endif

    // Extension to WIDTH+1 bits makes bit WIDTH the true sign / carry / borrow.
    always_comb begin
        is_add      = (ALUFun == ALU_ADD);
        ext_a       = {Sign & inA[WIDTH-1], inA};
        ext_b       = {Sign & inB[WIDTH-1], inB};
        sum         = is_add ? ext_a + ext_b : ext_a - ext_b;
        add_flags.z = (sum[WIDTH-1:0] == '0);
        if (Sign) begin
            add_flags.v = sum[WIDTH] ^ sum[WIDTH-1];
            add_flags.n = sum[WIDTH-1] ^ add_flags.v;
        end else begin
            add_flags.v = sum[WIDTH];
            add_flags.n = sum[WIDTH] & ~is_add;
        end
    end

    always_comb begin
        a_sign    = Sign & inA[WIDTH-1];
        a_zero    = (inA == '0);
        logic_res = '0;
        cmp_bit   = 1'b0;
        legal     = 1'b1;
`ifdef ALU_PIPE_MULT_EN
        is_mul    = 1'b0;
`endif
        case (ALUFun)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA: ;
            ALU_AND:   logic_res = inA & inB;
            ALU_OR:    logic_res = inA | inB;
            ALU_XOR:   logic_res = inA ^ inB;
            ALU_NOR:   logic_res = ~(inA | inB);
            ALU_PASSA: logic_res = inA;
            ALU_EQ:    cmp_bit = add_flags.z;
            ALU_NE:    cmp_bit = ~add_flags.z;
            ALU_LT:    cmp_bit = add_flags.n;
            ALU_LEZ:   cmp_bit = a_sign | a_zero;
            ALU_LTZ:   cmp_bit = a_sign;
            ALU_GTZ:   cmp_bit = ~a_sign & ~a_zero;
`ifdef ALU_PIPE_MULT_EN
            ALU_MUL:   is_mul = 1'b1;
`endif
            default:   legal = 1'b0;
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .amt   (inA[SHW-1:0]),
        .data  (inB),
        .left  (~ALUFun[0]),
        .arith (ALUFun[1]),
        .result(shift_res)
    );

    always_comb begin
        s2_adv = ~out_valid_q | out_ready;
        s1_adv = ~s1_valid_q | s2_adv;
`ifdef ALU_PIPE_MULT_EN
        in_ready = s1_adv & (mul_state_q == MUL_IDLE);
`else
        in_ready = s1_adv;
`endif
        accept = in_valid & in_ready;
    end

`ifdef ALU_PIPE_MULT_EN
    // Right-shifting shift-add: acc = {partial product, remaining multiplier}.
    always_comb begin
        mul_hi_sum = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]} + (mul_acc_q[0] ? {1'b0, mul_a_q} : '0);
        mul_step   = {mul_hi_sum, mul_acc_q[WIDTH-1:1]};
        mul_hi_s   = mul_step[2*WIDTH-1:WIDTH] - (mul_a_q[WIDTH-1] ? mul_b_q : '0)
                                               - (mul_b_q[WIDTH-1] ? mul_a_q : '0);
        mul_v      = mul_sign_q ? (mul_hi_s != {WIDTH{mul_step[WIDTH-1]}})
                                : (mul_step[2*WIDTH-1:WIDTH] != '0);
    end
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_flags_d = s1_flags_q;
        s1_logic_d = s1_logic_q;
        s1_shift_d = s1_shift_q;
        s1_cmp_d   = s1_cmp_q;
        s1_cls_d   = s1_cls_q;
        s1_tag_d   = s1_tag_q;
        s1_ill_d   = s1_ill_q;
        if (s1_adv) s1_valid_d = accept;
        if (accept) begin
            s1_sum_d   = sum[WIDTH-1:0];
            s1_flags_d = add_flags;
            s1_logic_d = logic_res;
            s1_shift_d = shift_res;
            s1_cmp_d   = cmp_bit;
            s1_cls_d   = ALUFun[5:4];
            s1_tag_d   = in_tag;
            s1_ill_d   = ~legal;
        end
`ifdef ALU_PIPE_MULT_EN
        mul_state_d = mul_state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_acc_d   = mul_acc_q;
        mul_sign_d  = mul_sign_q;
        case (mul_state_q)
            MUL_IDLE: if (accept && is_mul) begin
                s1_valid_d  = 1'b0;
                mul_state_d = MUL_BUSY;
                mul_cnt_d   = '0;
                mul_a_d     = inA;
                mul_b_d     = inB;
                mul_acc_d   = {{WIDTH{1'b0}}, inB};
                mul_sign_d  = Sign;
            end
            MUL_BUSY: begin
                mul_acc_d = mul_step;
                mul_cnt_d = mul_cnt_q + 1'b1;
                if (mul_cnt_q == SHW'(WIDTH - 1)) begin
                    mul_state_d  = MUL_DONE;
                    s1_valid_d   = 1'b1;
                    s1_sum_d     = mul_step[WIDTH-1:0];
                    s1_flags_d.z = (mul_step[WIDTH-1:0] == '0);
                    s1_flags_d.v = mul_v;
                    s1_flags_d.n = mul_sign_q & mul_step[WIDTH-1];
                end
            end
            MUL_DONE: if (s2_adv) mul_state_d = MUL_IDLE;
            default:  mul_state_d = MUL_IDLE;
        endcase
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_z_d     = out_z_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;
        out_ill_d   = out_ill_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                case (s1_cls_q)
                    CLS_ARITH: out_z_d = s1_sum_q;
                    CLS_LOGIC: out_z_d = s1_logic_q;
                    CLS_SHIFT: out_z_d = s1_shift_q;
                    default:   out_z_d = {{(WIDTH-1){1'b0}}, s1_cmp_q};
                endcase
                if (s1_ill_q) out_z_d = '0;
                out_tag_d   = s1_tag_q;
                out_flags_d = s1_flags_q;
                out_ill_d   = s1_ill_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_flags_q  <= '0;
            s1_logic_q  <= '0;
            s1_shift_q  <= '0;
            s1_cmp_q    <= 1'b0;
            s1_cls_q    <= '0;
            s1_tag_q    <= '0;
            s1_ill_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_flags_q  <= s1_flags_d;
            s1_logic_q  <= s1_logic_d;
            s1_shift_q  <= s1_shift_d;
            s1_cmp_q    <= s1_cmp_d;
            s1_cls_q    <= s1_cls_d;
            s1_tag_q    <= s1_tag_d;
            s1_ill_q    <= s1_ill_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
            out_ill_q   <= out_ill_d;
        end
    end

`ifdef ALU_PIPE_MULT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_state_q <= MUL_IDLE;
            mul_cnt_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_acc_q   <= '0;
            mul_sign_q  <= 1'b0;
        end else begin
            mul_state_q <= mul_state_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_acc_q   <= mul_acc_d;
            mul_sign_q  <= mul_sign_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign outZ      = out_z_q;
    assign out_tag   = out_tag_q;
    assign flagZ     = out_flags_q.z;
    assign flagV     = out_flags_q.v;
    assign flagN     = out_flags_q.n;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32, TAG_W=5).
module tb_alu_pipe;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b011000, OP_OR = 6'b011110, OP_XOR = 6'b010110;
    localparam logic [5:0] OP_NOR = 6'b010001, OP_PASSA = 6'b011010;
    localparam logic [5:0] OP_SLL = 6'b100000, OP_SRL = 6'b100001, OP_SRA = 6'b100011;
    localparam logic [5:0] OP_EQ = 6'b110011, OP_NE = 6'b110001, OP_LT = 6'b110101;
    localparam logic [5:0] OP_LEZ = 6'b111101, OP_LTZ = 6'b111011, OP_GTZ = 6'b111111;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, Sign, out_valid, out_ready;
    logic        flagZ, flagV, flagN, illegal;
    logic [31:0] inA, inB, outZ;
    logic [5:0]  ALUFun;
    logic [4:0]  in_tag, out_tag;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .Sign(Sign), .ALUFun(ALUFun), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .outZ(outZ), .out_tag(out_tag),
        .flagZ(flagZ), .flagV(flagV), .flagN(flagN), .illegal(illegal)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issues one op with out_ready high and waits for its result; lat counts edges from the accept edge.
    task automatic do_op(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [4:0] tag,
                         output logic [31:0] z, output logic [4:0] t,
                         output logic fz, output logic fv, output logic fn, output logic ill,
                         output int lat);
        int k;
        ALUFun = fun; inA = a; inB = b; Sign = sgn; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        z = outZ; t = out_tag; fz = flagZ; fv = flagV; fn = flagN; ill = illegal;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        inA = '0; inB = '0; Sign = 1'b0; ALUFun = OP_ADD; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (outZ !== 32'h0) begin errors++; $display("FAIL rst_outZ got %h want 0", outZ); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL rst_tag got %h want 0", out_tag); end
        checks++; if ({flagZ, flagV, flagN, illegal} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {flagZ, flagV, flagN, illegal}); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat;
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd1, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'h8000_0000) begin errors++; $display("FAIL add_s_z got %h want 80000000", z); end
        checks++; if ({fv, fn} !== 2'b10) begin errors++; $display("FAIL add_s_vn got %b want 10", {fv, fn}); end
        checks++; if (t !== 5'd1) begin errors++; $display("FAIL add_s_tag got %0d want 1", t); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 5'd2, z, t, fz, fv, fn, ill, lat);
        checks++; if ({z, fv, fn} !== {32'h8000_0000, 2'b00}) begin errors++; $display("FAIL add_u got %h/%b want 80000000/00", z, {fv, fn}); end
        do_op(OP_SUB, 32'd3, 32'd5, 1'b1, 5'd3, z, t, fz, fv, fn, ill, lat);
        checks++; if ({z, fn, fv} !== {32'hFFFF_FFFE, 2'b10}) begin errors++; $display("FAIL sub_s got %h n%b v%b want fffffffe n1 v0", z, fn, fv); end
        do_op(OP_LT, 32'd3, 32'd5, 1'b0, 5'd4, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'd1) begin errors++; $display("FAIL lt_u_3_5 got %h want 1", z); end
        do_op(OP_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd5, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'd0) begin errors++; $display("FAIL lt_u_max_1 got %h want 0", z); end
        do_op(OP_LT, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'd1) begin errors++; $display("FAIL lt_s_m1_1 got %h want 1", z); end
    endtask

    task automatic test_logic();
        logic [5:0]  ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_PASSA};
        logic [31:0] exp [5] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h000F_00CB, 32'hF0F0_1234};
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 5'(i), z, t, fz, fv, fn, ill, lat);
            checks++; if (z !== exp[i]) begin errors++; $display("FAIL logic_%0d got %h want %h", i, z, exp[i]); end
        end
    endtask

    task automatic test_shift();
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat;
        do_op(OP_SRA, 32'h24, 32'h8000_0000, 1'b0, 5'd7, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h want f8000000", z); end
        do_op(OP_SRL, 32'h24, 32'h8000_0000, 1'b0, 5'd8, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h want 08000000", z); end
        do_op(OP_SLL, 32'd31, 32'd1, 1'b0, 5'd9, z, t, fz, fv, fn, ill, lat);
        checks++; if (z !== 32'h8000_0000) begin errors++; $display("FAIL sll31 got %h want 80000000", z); end
    endtask

    task automatic test_compare();
        logic [5:0]  ops [11] = '{OP_EQ, OP_NE, OP_NE, OP_LEZ, OP_LEZ, OP_LEZ, OP_LTZ, OP_LTZ, OP_GTZ, OP_GTZ, OP_GTZ};
        logic [31:0] as  [11] = '{32'd5, 32'd5, 32'd5, 32'd0, 32'h8000_0000, 32'd5, 32'h8000_0000,
                                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] bs  [11] = '{32'd5, 32'd5, 32'd6, 32'h1234_5678, 32'h1234_5678, 32'd0, 32'h1,
                                  32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF};
        logic        sg  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ex  [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], sg[i], 5'(i), z, t, fz, fv, fn, ill, lat);
            checks++; if (z !== {31'b0, ex[i]}) begin errors++; $display("FAIL cmp_%0d got %h want %0d", i, z, ex[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat;
        do_op(6'b000111, 32'd5, 32'd5, 1'b1, 5'd10, z, t, fz, fv, fn, ill, lat);
        checks++; if ({ill, z} !== {1'b1, 32'h0}) begin errors++; $display("FAIL illegal_op got ill%b z%h want ill1 z0", ill, z); end
        checks++; if ({fz, fv, fn} !== 3'b100) begin errors++; $display("FAIL illegal_flags got %b want 100", {fz, fv, fn}); end
        checks++; if ({t, lat} !== {5'd10, 2}) begin errors++; $display("FAIL illegal_flow got tag%0d lat%0d want tag10 lat2", t, lat); end
        do_op(OP_ADD, 32'd1, 32'd1, 1'b0, 5'd11, z, t, fz, fv, fn, ill, lat);
        checks++; if ({ill, z} !== {1'b0, 32'd2}) begin errors++; $display("FAIL legal_after got ill%b z%h want ill0 z2", ill, z); end
`ifndef ALU_PIPE_MULT_EN
        do_op(OP_MUL, 32'h1_0000, 32'h1_0000, 1'b0, 5'd12, z, t, fz, fv, fn, ill, lat);
        checks++; if ({ill, z} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mul_disabled got ill%b z%h want ill1 z0", ill, z); end
`endif
    endtask

`ifdef ALU_PIPE_MULT_EN
    task automatic test_mul();
        logic [31:0] z; logic [4:0] t; logic fz, fv, fn, ill; int lat; logic ready_seen;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        ALUFun = OP_MUL; inA = 32'h1_0000; inB = 32'h1_0000; Sign = 1'b0; in_tag = 5'd13; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_idle_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        checks++; if ({outZ, flagV} !== {32'h0, 1'b1}) begin errors++; $display("FAIL mul_big got %h v%b want 0 v1", outZ, flagV); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d want 34", lat); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL mul_in_ready got high want low"); end
        do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd14, z, t, fz, fv, fn, ill, lat);
        checks++; if ({z, fv, ill} !== {32'hFFFF_FFEB, 2'b00}) begin errors++; $display("FAIL mul_signed got %h v%b ill%b want ffffffeb v0 ill0", z, fv, ill); end
    endtask
`endif

    task automatic test_back_to_back();
        int sent, recv, cyc, extra;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        sent = 0; recv = 0; cyc = 0;
        while (recv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 8);
            ALUFun = OP_ADD; inA = 32'(sent * 3); inB = 32'd100; Sign = 1'b0; in_tag = 5'(sent + 1);
            #1;
            if (!out_ready) begin
                checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL b2b_stall_hs cyc%0d got v%b r%b want v1 r0", cyc, out_valid, in_ready); end
                checks++; if ({outZ, out_tag} !== {32'(recv * 3 + 100), 5'(recv + 1)}) begin errors++; $display("FAIL b2b_stall_hold cyc%0d got %h/%0d want %h/%0d", cyc, outZ, out_tag, recv * 3 + 100, recv + 1); end
            end
            if (out_valid && out_ready) begin
                checks++; if ({outZ, out_tag} !== {32'(recv * 3 + 100), 5'(recv + 1)}) begin errors++; $display("FAIL b2b_out_%0d got %h/%0d want %h/%0d", recv, outZ, out_tag, recv * 3 + 100, recv + 1); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 8 || sent !== 8) begin errors++; $display("FAIL b2b_count got sent%0d recv%0d want 8/8", sent, recv); end
        checks++; if (cyc !== 13) begin errors++; $display("FAIL b2b_cycles got %0d want 13", cyc); end
        extra = 0;
        repeat (4) begin if (out_valid) extra++; @(posedge clk); #1; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_dup got %0d extra want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; ALUFun = OP_ADD; Sign = 1'b0;
        inA = 32'd1; inB = 32'd1; in_tag = 5'd3;
        @(posedge clk); #1;
        inA = 32'd2; inB = 32'd2; in_tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({out_valid, outZ, out_tag, illegal} !== {1'b0, 32'h0, 5'h0, 1'b0}) begin errors++; $display("FAIL mid_reset got v%b z%h t%0d want 0/0/0", out_valid, outZ, out_tag); end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
        stale = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) stale++; end
        checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_compare();
        test_illegal();
`ifdef ALU_PIPE_MULT_EN
        test_mul();
`endif
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU. Uses the same 6-bit ALUFun encoding.
- Sits between the decode/register-read stage and writeback in the pipelined MIPS core.
- Accepts one operation per cycle under a valid/ready handshake and returns result, flags and a passthrough tag two cycles later.
- Backpressure stalls both stages losslessly.

Parameters:
- WIDTH, 32: operand and result width; must be ≥8 and a power of two.
- TAG_W, 5: width of the opaque tag carried alongside each operation (destination register number).

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- in_valid  in  1: operation offered.
- in_ready  out  1: operation accepted this cycle when in_valid & in_ready.
- inA  in  WIDTH: operand A; also the shift amount source.
- inB  in  WIDTH: operand B; also the shifted operand.
- Sign  in  1: 1 = signed flag/compare semantics, 0 = unsigned.
- ALUFun  in  6: operation code.
- in_tag  in  TAG_W: passthrough tag.
- out_valid  out  1: result available.
- out_ready  in  1: consumer accepts when out_valid & out_ready.
- outZ  out  WIDTH: result.
- out_tag  out  TAG_W: tag of the result.
- flagZ, flagV, flagN  out  1 each: adder flags of the result's operation.
- illegal  out  1: ALUFun was not a defined code.

Behaviour:
- Operation encoding:
  - Arithmetic: ADD 000000, SUB 000001.
  - Logic: AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010.
  - Shift: SLL 100000, SRL 100001, SRA 100011. Shift amount is inA[log2(WIDTH)-1:0]; the upper bits of inA are ignored.
  - Compare: EQ 110011, NE 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111. Result is {WIDTH-1 zeros, flag}.
- Adder:
  - Computes A+B (ADD) or A-B (all other codes), using WIDTH+1-bit extension: sign-extend when Sign=1, zero-extend when Sign=0.
  - Z = (truncated WIDTH-bit result == 0).
  - Signed V = two's-complement overflow. Unsigned V = carry-out on ADD, borrow on SUB/compare.
  - Signed N = result MSB xor V (true sign). Unsigned N = borrow.
- Compare semantics:
  - EQ=Z, NE=~Z, LT=N.
  - LEZ/LTZ/GTZ compare inA against zero (inB is ignored): LEZ = sign|zero, LTZ = sign, GTZ = ~sign & ~zero of inA.
  - When Sign=0, LTZ is always 0, LEZ = (inA==0), GTZ = (inA!=0).
- Pipeline:
  - S1 registers the adder sum with flags, the logic result, the shifter result, the decoded class, the tag and the illegal flag.
  - S2 selects by ALUFun[5:4] and registers the outputs.
  - Latency: the accepting cycle is edge 0 and the result is valid after edge 2. Throughput is 1 op/cycle.
- Handshake:
  - S2 advances when ~out_valid | out_ready.
  - S1 advances when ~s1_valid | S2 advances.
  - in_ready = S1 can accept; it is combinational from out_ready through the two stages, with no combinational path from in_valid.
  - outZ, out_tag and flags hold stable while out_valid & ~out_ready.
  - Simultaneous accept and emit in the same cycle is legal with no bubble.
- Illegal ALUFun: outZ = 0, flags = adder flags, illegal = 1. The operation still flows through the pipe.
- Reset, including mid-operation: in-flight operations are discarded.
  - out_valid = 0, outZ = 0, out_tag = 0, flags = 0, illegal = 0.
  - in_ready = 1 after reset deasserts (MULT_EN idle).

Optional Feature:
- Macro ALU_PIPE_MULT_EN.
- Defined: adds MUL 000010 (low WIDTH bits of inA*inB; Sign ignored; V = 1 if the high half is nonzero for an unsigned product, or is not the sign-extension for a signed product).
  - Executed in S1 by a shift-add FSM with states IDLE → BUSY (WIDTH cycles) → DONE.
  - While BUSY/DONE, in_ready = 0 and S1 holds. DONE hands off to S2 when S2 can accept, then returns to IDLE.
  - MUL latency = WIDTH+2 cycles.
  - Reset during BUSY returns to IDLE and drops the operation.
- Not defined: 000010 is illegal.

Decomposition:
- alu_pkg:
  - ALUFun localparams for every code above, plus class codes ARITH/LOGIC/SHIFT/CMP.
  - Function clog2 for the shift-amount width.
  - Flag struct {Z,V,N}.
- One sub-module, alu_shifter: combinational log2(WIDTH)-stage barrel shifter for SLL/SRL/SRA, instantiated in S1.

Test Plan:
- ADD 0x7FFFFFFF+1, Sign=1 → outZ=0x80000000, V=1, N=0. Same with Sign=0 → V=0, N=0.
- SUB 3-5: Sign=1 → outZ=0xFFFFFFFE, N=1. LT 3,5 with Sign=0 → outZ=1. LT 0xFFFFFFFF,1 with Sign=0 → 0; with Sign=1 → 1.
- SRA inA=0x24 (amount 4), inB=0x80000000 → 0xF8000000. SRL with the same operands → 0x08000000. SLL amount 31 on 1 → 0x80000000.
- Back-to-back stream of 8 ops with out_ready low for 3 cycles mid-stream → no loss or duplication, in-order tags, outputs stable during the stall, in_ready low once both stages are full.
- ALUFun=000111 → illegal=1, outZ=0. Reset asserted with 2 ops in flight → out_valid=0 immediately, no stale result after release.
- (MULT_EN) MUL 0x10000*0x10000 → outZ=0, V=1, valid 34 cycles after accept, in_ready low throughout. Without the macro → illegal=1.
